// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a registered carry, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Holds the WIDTH-1 most recently produced sum bits; the last bit is merged on the final edge.
  logic [WIDTH-2:0] part_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  assign s_bit    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_next   = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign sum_next = {s_bit, part_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            part_q  <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= c_next;
          part_q  <= sum_next[WIDTH-1:1];
          if (cnt_q == CntLast) begin
            sum_q   <= sum_next;
            cout_q  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB slice at this point.
            ovf_q   <= carry_q ^ c_next;
`endif
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=13 with an arithmetic reference model.
// Build with SERIAL_ADDER_OVF_EN defined to also check the ovf output.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start13 = 1'b0, cin13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        busy13, done13, cout13, ovf13;
  logic [12:0] sum13;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(13)) u_dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start13),
    .a     (a13),
    .b     (b13),
    .cin   (cin13),
    .busy  (busy13),
    .done  (done13),
    .sum   (sum13),
    .cout  (cout13)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf13)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf13 = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt8 = 0;
  bit mon_en = 1'b0;
  logic [31:0] q8[$];
  logic [31:0] q13[$];
  logic [8:0]  prev8 = '0;
  logic [13:0] prev13 = '0;

  // Expected {ovf, cout, sum} packed with sum in [w-1:0], cout at bit w, ovf at bit w+1.
  function automatic logic [31:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    longint unsigned t;
    logic [31:0] s, r;
    t = 64'(a) + 64'(b) + 64'(c);
    s = 32'(t % (64'd1 << w));
    r = s;
    r[w] = t[w];
`ifdef SERIAL_ADDER_OVF_EN
    r[w+1] = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard monitor and result-hold checker.
  always @(negedge clk) begin
    logic [31:0] g, e;
    if (mon_en && rst_n) begin
      if (done8) begin
        done_cnt8 <= done_cnt8 + 1;
        g = '0; g[7:0] = sum8; g[8] = cout8; g[9] = ovf8;
        if (q8.size() == 0) begin
          timeout("done8_unexpected");
        end else begin
          e = q8.pop_front();
          check("result8", g, e);
        end
      end else begin
        check("hold8", {23'd0, cout8, sum8}, {23'd0, prev8});
      end
      if (done13) begin
        g = '0; g[12:0] = sum13; g[13] = cout13; g[14] = ovf13;
        if (q13.size() == 0) begin
          timeout("done13_unexpected");
        end else begin
          e = q13.pop_front();
          check("result13", g, e);
        end
      end else begin
        check("hold13", {18'd0, cout13, sum13}, {18'd0, prev13});
      end
    end
    prev8  <= {cout8, sum8};
    prev13 <= {cout13, sum13};
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while (busy8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy8) timeout("idle8");
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(model(8, 32'(a), 32'(b), c));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int base, n;
    base = done_cnt8;
    issue8(a, b, c);
    n = 0;
    while (done_cnt8 == base && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt8 == base) timeout("run8_done");
  endtask

  initial begin
    int lat, base, n;

    #3 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy8), 0);
    check("reset_done", 32'(done8), 0);
    check("reset_sum", 32'(sum8), 0);
    check("reset_cout", 32'(cout8), 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First add with latency and busy checks.
    wait_idle8();
    a8 = 8'h3C; b8 = 8'h05; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model(8, 32'h3C, 32'h05, 1'b0));
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start8 = 1'b0;
        check("busy_after_start", 32'(busy8), 1);
      end
      if (done8) break;
    end
    check("latency", 32'(lat), 9);
    check("sum_3c_05", 32'(sum8), 32'h41);

    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h00, 8'h00, 1'b1);
    run8(8'h7F, 8'h01, 1'b0);
    run8(8'h80, 8'h80, 1'b0);
    run8(8'h05, 8'h03, 1'b0);

    // Start held high, operands disturbed mid-RUN.
    wait_idle8();
    base = done_cnt8;
    repeat (4) q8.push_back(model(8, 32'h10, 32'h20, 1'b0));
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 3) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
      end
      if (k % 10 == 8) begin
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_done_count", 32'(done_cnt8 - base), 4);
    check("held_start_sum", 32'(sum8), 32'h30);

    // Reset during the fourth RUN cycle.
    issue8(8'h5A, 8'h33, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    q8.delete();
    #1;
    check("midreset_busy", 32'(busy8), 0);
    check("midreset_done", 32'(done8), 0);
    check("midreset_sum", 32'(sum8), 0);
    check("midreset_cout", 32'(cout8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt8;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", 32'(done_cnt8 - base), 0);
    run8(8'h01, 8'h01, 1'b0);
    check("post_reset_sum", 32'(sum8), 32'h02);

    fork
      begin
        for (int i = 0; i < 1000; ) begin
          @(negedge clk);
          if (!busy8) begin
            if ($urandom_range(3) == 0) begin
              start8 = 1'b0;
            end else begin
              a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
              start8 = 1'b1;
              q8.push_back(model(8, 32'(a8), 32'(b8), cin8));
              i++;
            end
          end else begin
            start8 = ($urandom_range(3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
          end
        end
        @(negedge clk);
        start8 = 1'b0;
      end
      begin
        for (int i = 0; i < 1000; ) begin
          @(negedge clk);
          if (!busy13) begin
            if ($urandom_range(3) == 0) begin
              start13 = 1'b0;
            end else begin
              a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
              start13 = 1'b1;
              q13.push_back(model(13, 32'(a13), 32'(b13), cin13));
              i++;
            end
          end else begin
            start13 = ($urandom_range(3) == 0);
            a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
          end
        end
        @(negedge clk);
        start13 = 1'b0;
      end
    join

    n = 0;
    while ((q8.size() != 0 || q13.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue8_drained", 32'(q8.size()), 0);
    check("queue13_drained", 32'(q13.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
